// File: rtl/tdm_pkg.sv
// Shared types and defaults for the TDM receive path (and the future transmitter).
package tdm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ALIGN     = 2'd1,
        ST_RECV      = 2'd2,
        ST_WAIT_SYNC = 2'd3
    } tdm_state_e;

    localparam int DEF_SLOTS     = 8;
    localparam int DEF_SLOT_BITS = 32;
    localparam int DEF_DATA_BITS = 24;

    // Index width for a counter over n positions; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_rx_if.sv
// Parallel sample bus leaving the TDM receiver toward downstream audio processing.
interface tdm_rx_if
    import tdm_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SLOTS     = DEF_SLOTS
);
    localparam int SLOT_W = idx_w(SLOTS);

    logic [DATA_BITS-1:0] rx_data;
    logic [SLOT_W-1:0]    rx_slot;
    logic                 rx_valid;
    logic                 frame_start;
    logic                 rx_lock;
    logic                 frame_err;
    logic [15:0]          err_count;

    modport master (
        output rx_data, rx_slot, rx_valid, frame_start, rx_lock, frame_err, err_count
    );

    modport slave (
        input rx_data, rx_slot, rx_valid, frame_start, rx_lock, frame_err, err_count
    );

endinterface

// File: rtl/tdm_edge_sync.sv
// Two-flop synchronizer for bclk/wclk/serial data with bclk rising-edge detection.
module tdm_edge_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic bclk_i,
    input  logic wclk_i,
    input  logic data_i,
    output logic bclk_rise_o,
    output logic wclk_o,
    output logic data_o
);
    // Bit order in both stages: {bclk, wclk, data}; all three see equal latency.
    logic [2:0] meta_q;
    logic [2:0] sync_q;
    logic       bclk_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q      <= '0;
            sync_q      <= '0;
            bclk_prev_q <= 1'b0;
        end else begin
            meta_q      <= {bclk_i, wclk_i, data_i};
            sync_q      <= meta_q;
            bclk_prev_q <= sync_q[2];
        end
    end

    assign bclk_rise_o = sync_q[2] & ~bclk_prev_q;
    assign wclk_o      = sync_q[1];
    assign data_o      = sync_q[0];

endmodule

// File: rtl/tdm_rx.sv
// TDM receive deserializer in the mclk domain; one strobed word per slot.
// Optional saturating framing-error counter enabled by defining TDM_RX_ERR_CNT_EN.
module tdm_rx
    import tdm_pkg::*;
#(
    parameter int SLOTS     = DEF_SLOTS,
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int WS_DELAY  = 1
) (
    input  logic     mclk,
    input  logic     rst,
    input  logic     bclk,
    input  logic     wclk,
    input  logic     tdm_in,
    tdm_rx_if.master rx
);
    localparam int SW = idx_w(SLOTS);
    localparam int BW = idx_w(SLOT_BITS);
    localparam logic [BW-1:0] BIT_LAST  = BW'(SLOT_BITS - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SLOTS - 1);

    logic bclk_rise;
    logic wclk_s;
    logic data_s;

    tdm_edge_sync u_sync (
        .clk_i       (mclk),
        .rst_i       (rst),
        .bclk_i      (bclk),
        .wclk_i      (wclk),
        .data_i      (tdm_in),
        .bclk_rise_o (bclk_rise),
        .wclk_o      (wclk_s),
        .data_o      (data_s)
    );

    tdm_state_e           state_q;
    logic                 wclk_prev_q;
    logic [BW-1:0]        bit_cnt_q;
    logic [SW-1:0]        slot_cnt_q;
    logic [DATA_BITS-2:0] shift_q;
    logic [DATA_BITS-1:0] rx_data_q;
    logic [SW-1:0]        rx_slot_q;
    logic                 rx_valid_q;
    logic                 frame_start_q;
    logic                 rx_lock_q;
    logic                 frame_err_q;

    logic                 sync_ev;
    logic                 restart;
    logic                 take;
    logic [BW-1:0]        bit_idx;
    logic [SW-1:0]        slot_idx;
    logic [DATA_BITS-1:0] shift_d;

    // A sync restarts the frame from any state except ALIGN, where the bit is slot-0 data.
    assign sync_ev  = bclk_rise & wclk_s & ~wclk_prev_q;
    assign restart  = sync_ev && (state_q != ST_ALIGN);
    assign take     = bclk_rise && ((state_q == ST_ALIGN) ||
                                    (state_q == ST_RECV && !sync_ev) ||
                                    (restart && WS_DELAY == 0));
    assign bit_idx  = restart ? '0 : bit_cnt_q;
    assign slot_idx = restart ? '0 : slot_cnt_q;
    assign shift_d  = {shift_q, data_s};

    always_ff @(posedge mclk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            wclk_prev_q   <= 1'b0;
            bit_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_slot_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            rx_lock_q     <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_err_q   <= 1'b0;
            if (bclk_rise) begin
                wclk_prev_q <= wclk_s;
            end

            if (restart) begin
                frame_start_q <= 1'b1;
                bit_cnt_q     <= '0;
                slot_cnt_q    <= '0;
                state_q       <= (WS_DELAY != 0) ? ST_ALIGN : ST_RECV;
                if (state_q == ST_WAIT_SYNC) begin
                    rx_lock_q <= 1'b1;
                end else if (state_q == ST_RECV) begin
                    frame_err_q <= 1'b1;
                    rx_lock_q   <= 1'b0;
                end
            end else if (bclk_rise && state_q == ST_WAIT_SYNC) begin
                frame_err_q <= 1'b1;
                rx_lock_q   <= 1'b0;
                state_q     <= ST_IDLE;
            end else if (bclk_rise && state_q == ST_ALIGN) begin
                state_q <= ST_RECV;
            end

            // Capture one bit; trailing bits beyond DATA_BITS only advance the counters.
            if (take) begin
                if (bit_idx <= DATA_LAST) begin
                    shift_q <= shift_d[DATA_BITS-2:0];
                end
                if (bit_idx == DATA_LAST) begin
                    rx_valid_q <= 1'b1;
                    rx_data_q  <= shift_d;
                    rx_slot_q  <= slot_idx;
                end
                if (bit_idx == BIT_LAST) begin
                    bit_cnt_q <= '0;
                    if (slot_idx == SLOT_LAST) begin
                        slot_cnt_q <= '0;
                        state_q    <= ST_WAIT_SYNC;
                    end else begin
                        slot_cnt_q <= slot_idx + SW'(1);
                    end
                end else begin
                    bit_cnt_q  <= bit_idx + BW'(1);
                    slot_cnt_q <= slot_idx;
                end
            end
        end
    end

`ifdef TDM_RX_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge mclk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (frame_err_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rx.err_count = err_cnt_q;
`else
    assign rx.err_count = 16'h0000;
`endif

    assign rx.rx_data     = rx_data_q;
    assign rx.rx_slot     = rx_slot_q;
    assign rx.rx_valid    = rx_valid_q;
    assign rx.frame_start = frame_start_q;
    assign rx.rx_lock     = rx_lock_q;
    assign rx.frame_err   = frame_err_q;

endmodule
